// File: rtl/mem_access_if.sv
// Requester-side load/store handshake for mem_access_unit: a request channel and a response channel.
interface mem_access_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_byte, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_byte, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit on a word memory; byte stores go through read-modify-write.
// Optional misaligned-word trap enabled by defining MEM_ACCESS_ALIGN_CHECK_EN.
module mem_access_unit #(
  parameter int READ_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  mem_access_if.slave  bus,
  output logic [15:0]  address,
  output logic [31:0]  write_data,
  output logic         mem_write,
  output logic         mem_read,
  input  logic [31:0]  read_data
);

  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP} state_t;

  state_t      state, state_nxt;
  logic        byte_q;
  logic [15:0] addr_q;
  logic [31:0] wdata_q, word_q, rdata_q, merged;
  logic [2:0]  cnt;
  logic [7:0]  lane;
  logic        accept, misalign, rd_last;

  assign accept  = (state == IDLE) && bus.req_valid;
  assign rd_last = (cnt == 3'(READ_LAT - 1));

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign misalign = ~bus.req_byte && (bus.req_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign lane = 8'(read_data >> {addr_q[1:0], 3'b000});

  always_comb begin
    merged = word_q;
    merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Memory strobes decode straight from state so an async reset kills them at once.
  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    write_data    = '0;
    address       = '0;
    if (state != IDLE) address = {addr_q[15:2], 2'b00};
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (misalign)                         state_nxt = RESP;
          else if (bus.req_write && bus.req_byte) state_nxt = RMW_RD;
          else if (bus.req_write)               state_nxt = WR;
          else                                  state_nxt = RD;
        end
      end
      RD: begin
        mem_read = 1'b1;
        if (rd_last) state_nxt = RESP;
      end
      RMW_RD: begin
        mem_read = 1'b1;
        if (rd_last) state_nxt = RMW_WR;
      end
      WR: begin
        mem_write  = 1'b1;
        write_data = wdata_q;
        state_nxt  = RESP;
      end
      RMW_WR: begin
        mem_write  = 1'b1;
        write_data = merged;
        state_nxt  = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      if (accept) begin
        byte_q  <= bus.req_byte;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        rdata_q <= '0;
        cnt     <= '0;
      end
      if (mem_read) begin
        cnt <= cnt + 3'd1;
        if (rd_last) begin
          word_q <= read_data;
          if (state == RD) rdata_q <= byte_q ? {24'b0, lane} : read_data;
        end
      end
    end
  end

  assign bus.rsp_rdata = rdata_q;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         err_q <= 1'b0;
    else if (accept) err_q <= misalign;
  end
  assign bus.rsp_err = err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter READ_LAT, default 1, memory read latency in cycles (legal 1..8).
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  input  1  asynchronous, active-high reset.
REQ-004 Port req_valid  input  1  load/store request present.
REQ-005 Port req_ready  output  1  unit accepts request this cycle.
REQ-006 Port req_write  input  1  1 = store, 0 = load.
REQ-007 Port req_byte  input  1  1 = byte access, 0 = word access.
REQ-008 Port req_addr  input  16  byte address.
REQ-009 Port req_wdata  input  32  store data; byte store uses bits 7:0.
REQ-010 Port rsp_valid  output  1  response present.
REQ-011 Port rsp_ready  input  1  requester accepts response.
REQ-012 Port rsp_rdata  output  32  load data; byte load zero-extended; 0 for stores.
REQ-013 Port rsp_err  output  1  misaligned-access error flag.
REQ-014 Port address  output  16  memory address, bits 1:0 always 0.
REQ-015 Port write_data  output  32  memory write data.
REQ-016 Port mem_write  output  1  memory write strobe.
REQ-017 Port mem_read  output  1  memory read enable.
REQ-018 Port read_data  input  32  memory read data, valid READ_LAT cycles after mem_read rises.

Function
REQ-019 FSM states SHALL be IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge with req_valid and req_ready both 1, latching write/byte/addr/wdata.
REQ-021 Transitions on accept: word load -> RD; byte load -> RD; word store -> WR; byte store -> RMW_RD.
REQ-022 In RD and RMW_RD, mem_read SHALL be 1 for exactly READ_LAT cycles; read_data is captured on the last of these edges.
REQ-023 RD SHALL then go to RESP; RMW_RD SHALL then go to RMW_WR.
REQ-024 In WR, mem_write SHALL be 1 for one cycle with write_data = latched word, then RESP.
REQ-025 In RMW_WR, mem_write SHALL be 1 for one cycle with write_data = captured word with byte lane addr[1:0] (lane 0 = bits 7:0) replaced by wdata[7:0], other lanes unchanged; then RESP.
REQ-026 address SHALL be {latched addr[15:2], 2'b00} while not IDLE, 0 in IDLE.
REQ-027 mem_read and mem_write SHALL never be 1 in the same cycle.
REQ-028 Byte load rsp_rdata SHALL be {24'b0, selected lane}; word load rsp_rdata SHALL be the captured word.
REQ-029 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_err stable until rsp_ready=1; that edge returns to IDLE.
REQ-030 Latency, accept at edge T: word load rsp_valid from T+READ_LAT; word store from T+1; byte store from T+READ_LAT+1.
REQ-031 req_valid changes while not IDLE SHALL be ignored; no request queuing.

Reset
REQ-032 On rst=1, immediately: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, address=0, write_data=0, mem_write=0, mem_read=0.
REQ-033 Reset mid-operation (including during RMW_WR) SHALL drop mem_write without completing the write; the in-flight request is discarded, no response.

Configuration
REQ-034 Macro MEM_ACCESS_ALIGN_CHECK_EN defined: word access with addr[1:0] != 0 SHALL go IDLE -> RESP directly, no memory strobe, rsp_err=1, rsp_rdata=0.
REQ-035 Macro undefined: rsp_err SHALL be constant 0 and misaligned word accesses proceed with addr[1:0] ignored.

Verification
REQ-036 READ_LAT=1, memory word 0 = 0x11223344; word load addr 0 -> mem_read 1 cycle, rsp_rdata=0x11223344, rsp_valid at T+1.
REQ-037 Word store addr 4 data 18, then word load addr 4 -> one mem_write pulse at address 4, load returns 0x00000012.
REQ-038 Word 4 = 0xAABBCCDD; byte store addr 6 data 0x55 -> read then write, memory word 4 = 0xAA55CCDD; byte load addr 6 -> 0x00000055.
REQ-039 READ_LAT=3, rsp_ready held 0 for 5 cycles -> mem_read high exactly 3 cycles, rsp_valid/rsp_rdata held stable, req_ready=0 throughout.
REQ-040 rst pulsed during RMW_WR of byte store addr 1 -> mem_write falls same cycle, no response, req_ready=1 next cycle.
REQ-041 With MEM_ACCESS_ALIGN_CHECK_EN, word load addr 2 -> no mem_read, rsp_err=1, rsp_rdata=0; without macro, same request reads word 0, rsp_err=0.
